// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one single-ported RAM between four cache requesters.
// One transaction at a time; a watchdog ends accesses that the RAM never acknowledges.
module mem_req_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic [3:0]   req_ren,
  input  logic [3:0]   req_wen,
  input  logic [127:0] req_addr,
  input  logic [127:0] req_store,
  output logic [3:0]   req_done,
  output logic         req_err,
  output logic [31:0]  req_load,
  output logic         busy,
  output logic         ramREN,
  output logic         ramWEN,
  output logic [31:0]  ramaddr,
  output logic [31:0]  ramstore,
  input  logic [31:0]  ramload,
  input  logic         ram_ready
);

  localparam int unsigned CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           r_state;
  logic [1:0]       r_grant;
  logic [1:0]       r_last;
  logic             r_wr;
  logic [CNT_W-1:0] r_cnt;

  logic [3:0]       w_pend;
  logic             w_any;
  logic [1:0]       w_pick;
  logic [31:0]      w_addr;
  logic [31:0]      w_store;
  logic             w_wr;

  assign w_pend = req_ren | req_wen;
  assign w_any  = |w_pend;

  // Scan from farthest to nearest so the nearest pending index after r_last wins.
  always_comb begin
    w_pick = r_last;
    for (int k = 4; k >= 1; k--) begin
      if (w_pend[r_last + 2'(k)]) w_pick = r_last + 2'(k);
    end
  end

  assign w_addr  = req_addr[{w_pick, 5'd0} +: 32];
  assign w_store = req_store[{w_pick, 5'd0} +: 32];
  assign w_wr    = req_wen[w_pick];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_grant  <= 2'd0;
      r_last   <= 2'd3;
      r_wr     <= 1'b0;
      r_cnt    <= '0;
      req_done <= 4'd0;
      req_err  <= 1'b0;
      req_load <= 32'd0;
      busy     <= 1'b0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= 32'd0;
      ramstore <= 32'd0;
    end else begin
      req_done <= 4'd0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant  <= w_pick;
            r_wr     <= w_wr;
            ramaddr  <= w_addr;
            ramstore <= w_store;
            ramWEN   <= w_wr;
            ramREN   <= ~w_wr;
            r_cnt    <= '0;
            busy     <= 1'b1;
            r_state  <= ACCESS;
          end
        end
        ACCESS: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // An acknowledge on the final watchdog cycle still counts as success.
          if (ram_ready) begin
            if (!r_wr) req_load <= ramload;
            req_err           <= 1'b0;
            ramREN            <= 1'b0;
            ramWEN            <= 1'b0;
            req_done[r_grant] <= 1'b1;
            r_state           <= DONE;
          end else if (r_cnt == CNT_LAST) begin
            req_load          <= 32'd0;
            req_err           <= 1'b1;
            ramREN            <= 1'b0;
            ramWEN            <= 1'b0;
            req_done[r_grant] <= 1'b1;
            r_state           <= DONE;
          end
        end
        DONE: begin
          r_last  <= r_grant;
          req_err <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
